// File: rtl/pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pic_pkg
//  Description : Shared constants for the PIC-style instruction sequencer:
//                instruction class codes, opcode fields, the Q-phase enum
//                and the special instruction words (NOP, RETURN).
//  Revision    : 1.0 - initial release
// ============================================================================
package pic_pkg;

    localparam int INST_W = 14;

    // Four clocks per instruction cycle.
    typedef enum logic [1:0] {
        Q1 = 2'd0,
        Q2 = 2'd1,
        Q3 = 2'd2,
        Q4 = 2'd3
    } q_phase_e;

    // Instruction class, ir[13:12]
    localparam logic [1:0] CLS_BYTE = 2'b00;
    localparam logic [1:0] CLS_BIT  = 2'b01;
    localparam logic [1:0] CLS_CTRL = 2'b10;
    localparam logic [1:0] CLS_LIT  = 2'b11;

    // Byte-class opcodes, ir[11:8]
    localparam logic [3:0] OP_DECFSZ = 4'b1011;
    localparam logic [3:0] OP_INCFSZ = 4'b1111;

    // Bit-class opcodes, ir[13:10]
    localparam logic [3:0] OP_BCF   = 4'b0100;
    localparam logic [3:0] OP_BSF   = 4'b0101;
    localparam logic [3:0] OP_BTFSC = 4'b0110;
    localparam logic [3:0] OP_BTFSS = 4'b0111;

    // MOVWF is ir[11:7] = 00001 inside the byte class
    localparam logic [4:0] MOVWF_PFX = 5'b00001;

    localparam logic [INST_W-1:0] NOP_WORD    = 14'h0000;
    localparam logic [INST_W-1:0] RETURN_WORD = 14'h0008;

    function automatic logic [1:0] inst_class(input logic [INST_W-1:0] inst);
        return inst[13:12];
    endfunction

endpackage : pic_pkg
`default_nettype wire

// File: rtl/pic_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pic_sequencer_if
//  Description : Bus between the sequencer and its surroundings (program
//                memory, decoder, ALU, register file).
//                master : the sequencer (drives PC, IR, phase, strobes)
//                slave  : the environment (drives program word, d, ALU
//                         flags, stall)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pic_sequencer_if #(
    parameter int PC_W = 11
) ();

    logic [13:0]     prog_data;
    logic            d;
    logic            alu_zero;
    logic            bit_val;
    logic            stall;
    logic [PC_W-1:0] prog_addr;
    logic [13:0]     ir;
    logic [7:0]      dec_inst;
    logic [1:0]      q_phase;
    logic            f_re;
    logic            w_we;
    logic            f_we;
    logic            flush;
    logic            stack_ovf;

    modport master (
        input  prog_data, d, alu_zero, bit_val, stall,
        output prog_addr, ir, dec_inst, q_phase, f_re, w_we, f_we, flush,
               stack_ovf
    );

    modport slave (
        output prog_data, d, alu_zero, bit_val, stall,
        input  prog_addr, ir, dec_inst, q_phase, f_re, w_we, f_we, flush,
               stack_ovf
    );

endinterface : pic_sequencer_if
`default_nettype wire

// File: rtl/pic_stack.sv
`default_nettype none
// ============================================================================
//  Module      : pic_stack
//  Description : Circular return-address stack.
//                push/pop      : one operation per clock (push has priority)
//                push_data     : address written on push
//                pop_data      : entry below the pointer (value a pop returns)
//                ovf           : sticky, set by a push while already full
//                The pointer wraps modulo DEPTH, so a push when full
//                overwrites the oldest entry and a pop when empty returns
//                the wrapped entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_stack #(
    parameter int DEPTH = 8,
    parameter int W     = 11
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire logic [W-1:0] push_data,
    output logic      [W-1:0] pop_data,
    output logic              ovf
);

    localparam int             PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];

    assign top_idx  = sp_q - PTR_W'(1);
    assign pop_data = mem_q[top_idx];
    assign ovf      = ovf_q;

    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        mem_d = mem_q;
        if (push) begin
            mem_d[sp_q] = push_data;
            sp_d        = sp_q + PTR_W'(1);
            // The occupancy count only tracks "full" vs "empty"; once full
            // it stays full and the wrapped write replaces the oldest entry.
            if (cnt_q == FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + (PTR_W+1)'(1);
            end
        end else if (pop) begin
            sp_d = top_idx;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            mem_q <= mem_d;
        end
    end

endmodule : pic_stack
`default_nettype wire

// File: rtl/pic_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pic_sequencer
//  Description : Instruction-cycle controller. Runs the Q1..Q4 phase counter,
//                the program counter, the instruction register and the
//                per-phase strobes. The next word is fetched (prog_addr)
//                while the current one (ir) executes; control transfers and
//                taken skips load a NOP bubble instead of the fetched word.
//                clk, rst_n : clock, asynchronous active-low reset
//                bus        : pic_sequencer_if master (program word, decoder
//                             d, ALU flags, stall in; PC, IR, phase,
//                             strobes, flush, stack_ovf out)
//  Revision    : 1.0 - initial release
// ============================================================================
module pic_sequencer
    import pic_pkg::*;
#(
    parameter int PC_W        = 11,
    parameter int STACK_DEPTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    pic_sequencer_if.master    bus
);

    q_phase_e        phase_q, phase_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [13:0]     ir_q, ir_d;
    logic            flush_q, flush_d;

    logic            push;
    logic            pop;
    logic [PC_W-1:0] ret_addr;
    logic            stk_ovf;

    // ------------------------------------------------------------------
    // Instruction decode (only meaningful when not in a bubble)
    // ------------------------------------------------------------------
    logic [1:0] cls;
    logic [3:0] byte_op;
    logic [3:0] bit_op;
    logic       is_movwf;
    logic       is_branch;
    logic       is_call;
    logic       is_return;
    logic       skip_taken;
    logic       redirect;
    logic       cycle_end;
    logic       f_we_cond;
    logic       w_we_cond;

    assign cls      = inst_class(ir_q);
    assign byte_op  = ir_q[11:8];
    assign bit_op   = ir_q[13:10];
    assign is_movwf = (cls == CLS_BYTE) && (ir_q[11:7] == MOVWF_PFX);

    assign is_branch  = !flush_q && (cls == CLS_CTRL);
    assign is_call    = is_branch && !ir_q[11];
    assign is_return  = !flush_q && (ir_q == RETURN_WORD);
    assign skip_taken = !flush_q && (
                            ((cls == CLS_BYTE) && bus.alu_zero &&
                             ((byte_op == OP_DECFSZ) || (byte_op == OP_INCFSZ)))
                         || ((bit_op == OP_BTFSC) && !bus.bit_val)
                         || ((bit_op == OP_BTFSS) &&  bus.bit_val));
    assign redirect   = is_branch || is_return || skip_taken;

    // The Q4 -> Q1 edge is the only place control flow and the stack move.
    assign cycle_end  = (phase_q == Q4) && !bus.stall;

    assign f_we_cond = ((cls == CLS_BYTE) && bus.d)
                    || is_movwf
                    || (bit_op == OP_BCF)
                    || (bit_op == OP_BSF);

    assign w_we_cond = ((cls == CLS_BYTE) && !bus.d
                        && (ir_q != NOP_WORD)
                        && (ir_q != RETURN_WORD)
                        && !is_movwf)
                    || (cls == CLS_LIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        phase_d = phase_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flush_d = flush_q;
        push    = 1'b0;
        pop     = 1'b0;

        if (!bus.stall) begin
            phase_d = q_phase_e'(phase_q + 2'd1);
        end

        if (cycle_end) begin
            if (is_branch) begin
                pc_d = PC_W'(ir_q[10:0]);
                push = is_call;
            end else if (is_return) begin
                pc_d = ret_addr;
                pop  = 1'b1;
            end else begin
                // A taken skip also lands here: the fetched PC+1 word is
                // dropped below and fetching resumes one word further on.
                pc_d = pc_q + PC_W'(1);
            end

            if (redirect) begin
                ir_d    = NOP_WORD;
                flush_d = 1'b1;
            end else begin
                ir_d    = bus.prog_data;
                flush_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= Q1;
            pc_q    <= '0;
            ir_q    <= NOP_WORD;
            flush_q <= 1'b1;
        end else begin
            phase_q <= phase_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flush_q <= flush_d;
        end
    end

    // CALL pushes the fetch address, which is already the return address.
    pic_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (pc_q),
        .pop_data  (ret_addr),
        .ovf       (stk_ovf)
    );

    // ------------------------------------------------------------------
    // Outputs. Strobes decode from the registered phase, so a stall simply
    // stretches whichever strobe is active.
    // ------------------------------------------------------------------
    assign bus.prog_addr = pc_q;
    assign bus.ir        = ir_q;
    assign bus.dec_inst  = ir_q[13:6];
    assign bus.q_phase   = phase_q;
    assign bus.flush     = flush_q;
    assign bus.stack_ovf = stk_ovf;
    assign bus.f_re      = !flush_q && (phase_q == Q2)
                           && ((cls == CLS_BYTE) || (cls == CLS_BIT));
    assign bus.f_we      = !flush_q && (phase_q == Q4) && f_we_cond;
    assign bus.w_we      = !flush_q && (phase_q == Q4) && w_we_cond;

endmodule : pic_sequencer
`default_nettype wire
